// File: rtl/wb_dest_pipe.sv
// Destination-register pipeline: picks a write address from the instruction and carries
// it through DEPTH stages, with per-stage operand matching and a youngest-match forward select.
// Optional retired-write counter (retired_cnt port) when WBDEST_PERF_EN is defined.

module wb_dest_stage #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] rs_q,
    input  logic [ADDR_W-1:0] rt_q,
    output logic [ADDR_W-1:0] q_addr,
    output logic              q_we,
    output logic              rs_hit,
    output logic              rt_hit
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_addr <= '0;
            q_we   <= 1'b0;
        end else begin
            q_addr <= d_addr;
            q_we   <= d_we;
        end
    end

    // Register 0 is never a real producer, so a zero query never matches.
    assign rs_hit = q_we & (q_addr == rs_q) & (rs_q != '0);
    assign rt_hit = q_we & (q_addr == rt_q) & (rt_q != '0);

endmodule

module wb_dest_pipe #(
    parameter int          ADDR_W  = 5,
    parameter int          DEPTH   = 3,
    parameter int unsigned RA_ADDR = 31,
    localparam int         SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               instr,
    input  logic                      in_valid,
    input  logic [1:0]                dst_sel,
    input  logic                      reg_we,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         rs_q,
    input  logic [ADDR_W-1:0]         rt_q,
    output logic [DEPTH*ADDR_W-1:0]   stage_addr,
    output logic [DEPTH-1:0]          stage_we,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      wb_we,
    output logic [DEPTH-1:0]          rs_hit,
    output logic [DEPTH-1:0]          rt_hit,
    output logic [SEL_W-1:0]          rs_fwd,
    output logic [SEL_W-1:0]          rt_fwd
`ifdef WBDEST_PERF_EN
    ,output logic [31:0]              retired_cnt
`endif
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } dest_t;

    dest_t                       sel_d;
    logic                        bubble;
    logic [DEPTH:0]              vld_pipe;
    logic [DEPTH:0][ADDR_W-1:0]  addr_pipe;
    logic                        unused_instr;

    assign unused_instr = ^instr;

    always_comb begin
        sel_d.addr = '0;
        case (dst_sel)
            2'b01:   sel_d.addr = instr[16 +: ADDR_W];
            2'b10:   sel_d.addr = instr[11 +: ADDR_W];
            2'b11:   sel_d.addr = ADDR_W'(RA_ADDR);
            default: sel_d.addr = '0;
        endcase
        sel_d.we = in_valid & reg_we & (dst_sel != 2'b00) & (sel_d.addr != '0);
    end

    // Stall and flush both just turn the entering instruction into a bubble.
    assign bubble       = stall | flush;
    assign vld_pipe[0]  = sel_d.we & ~bubble;
    assign addr_pipe[0] = vld_pipe[0] ? sel_d.addr : '0;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            wb_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .d_addr (addr_pipe[k]),
                .d_we   (vld_pipe[k]),
                .rs_q   (rs_q),
                .rt_q   (rt_q),
                .q_addr (addr_pipe[k+1]),
                .q_we   (vld_pipe[k+1]),
                .rs_hit (rs_hit[k]),
                .rt_hit (rt_hit[k])
            );
        end
    endgenerate

    assign stage_addr = addr_pipe[DEPTH:1];
    assign stage_we   = vld_pipe[DEPTH:1];
    assign wb_addr    = addr_pipe[DEPTH];
    assign wb_we      = vld_pipe[DEPTH];

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        rs_fwd = '0;
        rt_fwd = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rs_hit[i]) rs_fwd = SEL_W'(i + 1);
            if (rt_hit[i]) rt_fwd = SEL_W'(i + 1);
        end
    end

`ifdef WBDEST_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (reset)      perf_cnt <= '0;
        else if (wb_we) perf_cnt <= perf_cnt + 32'd1;
    end

    assign retired_cnt = perf_cnt;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Bench for wb_dest_pipe: history-queue model checked every cycle, plus directed literal cases.
module tb_wb_dest_pipe;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int SEL_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic [31:0]             instr;
    logic                    in_valid;
    logic [1:0]              dst_sel;
    logic                    reg_we;
    logic                    stall;
    logic                    flush;
    logic [ADDR_W-1:0]       rs_q;
    logic [ADDR_W-1:0]       rt_q;
    logic [DEPTH*ADDR_W-1:0] stage_addr;
    logic [DEPTH-1:0]        stage_we;
    logic [ADDR_W-1:0]       wb_addr;
    logic                    wb_we;
    logic [DEPTH-1:0]        rs_hit;
    logic [DEPTH-1:0]        rt_hit;
    logic [SEL_W-1:0]        rs_fwd;
    logic [SEL_W-1:0]        rt_fwd;
`ifdef WBDEST_PERF_EN
    logic [31:0]             retired_cnt;
    logic [31:0]             exp_cnt;
`endif

    wb_dest_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RA_ADDR(31)) dut (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .dst_sel(dst_sel), .reg_we(reg_we), .stall(stall), .flush(flush),
        .rs_q(rs_q), .rt_q(rt_q), .stage_addr(stage_addr), .stage_we(stage_we),
        .wb_addr(wb_addr), .wb_we(wb_we), .rs_hit(rs_hit), .rt_hit(rt_hit),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd)
`ifdef WBDEST_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t hist[$];   // hist[k] = what stage k must hold (newest first)
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t entering();
        ent_t e;
        logic [ADDR_W-1:0] a;
        case (dst_sel)
            2'd1:    a = instr[20:16];
            2'd2:    a = instr[15:11];
            2'd3:    a = 5'd31;
            default: a = 5'd0;
        endcase
        e.we   = in_valid && reg_we && dst_sel != 0 && a != 0 && !stall && !flush;
        e.addr = e.we ? a : 5'd0;
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < DEPTH; i++) hist.push_back('{we: 1'b0, addr: '0});
`ifdef WBDEST_PERF_EN
            exp_cnt = 0;
`endif
        end else begin
`ifdef WBDEST_PERF_EN
            if (hist.size() == DEPTH && hist[DEPTH-1].we) exp_cnt = exp_cnt + 1;
`endif
            hist.push_front(entering());
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        logic [DEPTH-1:0]        ew, erh, eth;
        logic [DEPTH*ADDR_W-1:0] ea;
        logic [SEL_W-1:0]        erf, etf;
        if (chk_en) begin
            erf = 0;
            etf = 0;
            for (int i = 0; i < DEPTH; i++) begin
                ew[i] = hist[i].we;
                ea[i*ADDR_W +: ADDR_W] = hist[i].addr;
                erh[i] = hist[i].we && hist[i].addr == rs_q && rs_q != 0;
                eth[i] = hist[i].we && hist[i].addr == rt_q && rt_q != 0;
            end
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (erh[i]) erf = SEL_W'(i + 1);
                if (eth[i]) etf = SEL_W'(i + 1);
            end
            chk("stage_addr", stage_addr, ea);
            chk("stage_we", stage_we, ew);
            chk("wb_addr", wb_addr, hist[DEPTH-1].addr);
            chk("wb_we", wb_we, hist[DEPTH-1].we);
            chk("rs_hit", rs_hit, erh);
            chk("rt_hit", rt_hit, eth);
            chk("rs_fwd", rs_fwd, erf);
            chk("rt_fwd", rt_fwd, etf);
`ifdef WBDEST_PERF_EN
            chk("retired_cnt", retired_cnt, exp_cnt);
`endif
        end
    end

    task automatic drv(input logic [31:0] i, input logic v, input logic [1:0] s,
                       input logic w, input logic st, input logic fl);
        instr = i; in_valid = v; dst_sel = s; reg_we = w; stall = st; flush = fl;
    endtask

    task automatic idle();
        drv(32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [1:0]  sels [3] = '{2'd2, 2'd1, 2'd3};
    logic [4:0]  exps [3] = '{5'd8, 5'd10, 5'd31};
    logic [31:0] ri;

    initial begin
        reset = 1'b1; rs_q = '0; rt_q = '0;
        idle();
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // idle after reset: everything zero
        repeat (5) tick();
        chk("idle_stage_addr", stage_addr, 0);
        chk("idle_stage_we", stage_we, 0);
        chk("idle_wb", {wb_addr, wb_we}, 0);
        chk("idle_fwd", {rs_fwd, rt_fwd, rs_hit, rt_hit}, 0);

        // rd / rt / link selection, DEPTH-cycle latency
        for (int t = 0; t < 3; t++) begin
            drv(32'h012A4020, 1'b1, sels[t], 1'b1, 1'b0, 1'b0);
            tick();
            idle();
            tick(); tick();
            chk("sel_wb_addr", wb_addr, exps[t]);
            chk("sel_wb_we", wb_we, 1);
            chk("sel_stage_we", stage_we, 3'b100);
        end
        tick();

        // rt field is 0: write dropped
        drv(32'h00004020, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        rs_q = 0; #1;
        chk("r0_stage_we0", stage_we[0], 0);
        chk("r0_rs_hit", rs_hit, 0);
        chk("r0_rs_fwd", rs_fwd, 0);

        // back-to-back writes to $5: youngest stage wins
        drv(32'h00002800, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        idle();
        rs_q = 5; rt_q = 6; #1;
        chk("dup_rs_hit", rs_hit, 3'b011);
        chk("dup_rs_fwd", rs_fwd, 1);
        chk("dup_rt_hit", rt_hit, 0);
        chk("dup_rt_fwd", rt_fwd, 0);
        tick(); tick(); tick();

        // $7 then $9 under stall+flush
        drv(32'h00003800, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        drv(32'h00004800, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("sf_wb_addr7", wb_addr, 7);
        chk("sf_wb_we7", wb_we, 1);
        tick();
        chk("sf_wb_we9", wb_we, 0);
        chk("sf_stage_we", stage_we, 0);

        // reset with three writes in flight
        rs_q = 0; rt_q = 0;
        for (int a = 5; a < 8; a++) begin
            drv(32'(a) << 11, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
            tick();
        end
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        chk("rst_stage_we", stage_we, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_wb_we", wb_we, 0);
        end

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 600; c++) begin
            ri = $urandom;
            ri[20:16] = 5'($urandom_range(0, 7));
            ri[15:11] = 5'($urandom_range(0, 7));
            drv(ri, 1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
            reset = ($urandom_range(0, 49) == 0);
            rs_q = 5'($urandom_range(0, 7));
            rt_q = 5'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;
        idle();

`ifdef WBDEST_PERF_EN
        reset = 1'b1; tick(); reset = 1'b0;
        drv(32'h00001800, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        drv(32'h00002000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        drv(32'h00003000, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0); tick();
        drv(32'h00000000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        drv(32'h00006000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        idle();
        repeat (5) tick();
        chk("perf_cnt3", retired_cnt, 3);
        force dut.perf_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.perf_cnt;
        drv(32'h00001800, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        idle();
        repeat (4) tick();
        chk("perf_wrap", retired_cnt, 0);
`endif

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_dest_pipe.md
Name:
wb_dest_pipe

Overview:
- Parametrised successor to the single-cycle write-register address select.
- Each cycle it picks the destination register address from the instruction word: none, rt, rd or the link register. It then carries that address and its write-enable through DEPTH pipeline stages (stage 0 = EX ... stage DEPTH-1 = WB), with stall/flush bubble insertion.
- Also provides per-stage match vectors and a youngest-match forwarding select for two source operands.
- Sits between decode and the register file / forwarding muxes.

Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 3, number of pipeline stages tracked (legal range 1..8).
- RA_ADDR, 31, link register address used for dst_sel=11.
- SEL_W, $clog2(DEPTH+1), width of forwarding select outputs (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  decoded instruction word; rt=instr[20:16], rd=instr[15:11] (low ADDR_W bits used).
- in_valid  input  1  instr/dst_sel/reg_we describe a real instruction this cycle.
- dst_sel  input  2  00 none, 01 rt, 10 rd, 11 RA_ADDR.
- reg_we  input  1  instruction writes the register file.
- stall  input  1  insert bubble into stage 0; older stages advance.
- flush  input  1  insert bubble into stage 0; older stages advance.
- rs_q  input  ADDR_W  source operand 1 query address.
- rt_q  input  ADDR_W  source operand 2 query address.
- stage_addr  output  DEPTH*ADDR_W  packed stage addresses, stage k at [k*ADDR_W +: ADDR_W].
- stage_we  output  DEPTH  effective write-enable per stage.
- wb_addr  output  ADDR_W  equals stage DEPTH-1 address.
- wb_we  output  1  equals stage_we[DEPTH-1].
- rs_hit  output  DEPTH  per-stage match for rs_q.
- rt_hit  output  DEPTH  per-stage match for rt_q.
- rs_fwd  output  SEL_W  0 = no match, k+1 = youngest (lowest k) matching stage.
- rt_fwd  output  SEL_W  same, for rt_q.

Behaviour:
- Address select (combinational, on the input side):
  - 01 → rt; 10 → rd; 11 → RA_ADDR; 00 → 0.
  - Effective we_in = in_valid & reg_we & (dst_sel!=00) & (selected addr!=0).
  - Writes to register 0 are always dropped.
- Stage 0 load each clock:
  - If stall|flush: addr=0, we=0 (bubble). Both asserted together also gives a bubble.
  - Otherwise: addr = selected addr (forced to 0 when we_in=0), we=we_in.
- Stages k>=1 load stage k-1 every clock unconditionally. A bubble therefore retires from WB exactly DEPTH cycles after insertion.
- Latency: an instruction presented in cycle n appears on wb_addr/wb_we in cycle n+DEPTH (registered output).
- Reset: synchronous. All stage addr=0 and we=0, so every output is 0 (stage_addr=0, stage_we=0, wb_addr=0, wb_we=0, hits=0, fwd=0). Reset overrides stall/flush/in_valid. In-flight entries are discarded with no partial retirement.
- Hit logic (combinational from registered state and query inputs):
  - rs_hit[k] = stage_we[k] & (stage_addr[k]==rs_q) & (rs_q!=0). rt_hit is the same with rt_q.
  - rs_fwd = k+1 for the lowest k with rs_hit[k]=1, else 0. Priority goes to the youngest producer.
- Simultaneous matches in multiple stages: only the lowest index is reflected in *_fwd; all are reflected in *_hit.
- DEPTH=1: stage 0 is WB; fwd is 1 bit.

Optional Feature:
- Macro WBDEST_PERF_EN.
- When defined, adds output port retired_cnt (32 bits). It increments by 1 on every clock where wb_we=1 and reset is low, and wraps 0xFFFFFFFF → 0. It clears to 0 on reset.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles → all outputs 0. Assert reset for 1 cycle mid-stream with 3 valid writes in flight → next cycle stage_we=0, wb_we never pulses for those writes.
- instr=0x012A4020 (rd=8, rt=10), in_valid=1, reg_we=1, dst_sel=10, DEPTH=3 → 3 cycles later wb_addr=8, wb_we=1. Repeat with dst_sel=01 → wb_addr=10. Repeat with dst_sel=11 → wb_addr=31.
- dst_sel=01 with rt=0, reg_we=1 → stage_we[0]=0, and rs_q=0 gives rs_hit=000, rs_fwd=0.
- Issue write to $5 on consecutive cycles so stages 0 and 1 both hold 5; rs_q=5 → rs_hit=011, rs_fwd=1. rt_q=6 → rt_hit=000, rt_fwd=0.
- stall=1 and flush=1 on the same cycle as a valid write to $9 → no wb_we for $9. The preceding valid write to $7 still reaches WB on schedule.
- With WBDEST_PERF_EN: 4 valid writes, 1 stalled, 1 to $0 → retired_cnt=3 after drain. Preload the counter near wrap (force to 0xFFFFFFFF) and retire one write → retired_cnt=0.
